// File: rtl/vst_pkg.sv
// Shared types and helpers for the adaptive visual-acuity staircase controller.
//   - FSM state enum, staircase movement enum
//   - optotype direction codes (0=L, 1=R, 2=U, 3=D) and key one-hot mapping
//   - Galois LFSR geometry (8 bits, taps 8,6,5,4)
package vst_pkg;

  localparam int unsigned DIR_W  = 2;
  localparam int unsigned KEY_W  = 4;
  localparam int unsigned LFSR_W = 8;

  // Right-shift Galois mask for x^8 + x^6 + x^5 + x^4 + 1
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  localparam logic [DIR_W-1:0] DIR_L = 2'd0;
  localparam logic [DIR_W-1:0] DIR_R = 2'd1;
  localparam logic [DIR_W-1:0] DIR_U = 2'd2;
  localparam logic [DIR_W-1:0] DIR_D = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    PRESENT,
    WAIT_RESP,
    EVAL,
    DONE
  } vst_state_e;

  typedef enum logic [1:0] {
    NONE,
    UP,
    DOWN
  } vst_move_e;

  // One-hot key pattern that correctly answers a given direction
  function automatic logic [KEY_W-1:0] dir_to_key(input logic [DIR_W-1:0] d);
    logic [KEY_W-1:0] k;
    k = '0;
    case (d)
      DIR_L: k = 4'b0001;
      DIR_R: k = 4'b0010;
      DIR_U: k = 4'b0100;
      DIR_D: k = 4'b1000;
    endcase
    return k;
  endfunction

  // Next direction modulo 4, used to avoid repeating the previous optotype
  function automatic logic [DIR_W-1:0] dir_rot(input logic [DIR_W-1:0] d);
    return (d == DIR_D) ? DIR_L : d + DIR_W'(1);
  endfunction

endpackage

// File: rtl/vst_if.sv
// Key front-end / display side bus of the staircase controller.
//   key_restart, key_dir          : debounced key pulses into the controller
//   level_idx, optotype_dir,
//   show_valid, answer_ok/bad,
//   test_done, result_level/fail  : registered status towards the display drivers
// master = key/display side, slave = controller.
interface vst_if #(
  parameter int unsigned LVL_W = 3
);
  logic             key_restart;
  logic [3:0]       key_dir;
  logic [LVL_W-1:0] level_idx;
  logic [1:0]       optotype_dir;
  logic             show_valid;
  logic             answer_ok;
  logic             answer_bad;
  logic             test_done;
  logic [LVL_W-1:0] result_level;
  logic             result_fail;

  modport master (
    output key_restart, key_dir,
    input  level_idx, optotype_dir, show_valid, answer_ok, answer_bad,
    input  test_done, result_level, result_fail
  );

  modport slave (
    input  key_restart, key_dir,
    output level_idx, optotype_dir, show_valid, answer_ok, answer_bad,
    output test_done, result_level, result_fail
  );
endinterface

// File: rtl/vst_lfsr.sv
// 8-bit Galois LFSR (taps 8,6,5,4) producing the raw optotype direction.
//   clk, rst  : clock, synchronous active-high reset (loads seed)
//   seed      : load value; must be non-zero or the register locks at 0
//   advance   : step the register this cycle
//   dir_raw_c : low two bits of the stepped value (combinational)
module vst_lfsr
  import vst_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [LFSR_W-1:0] seed,
  input  logic              advance,
  output logic [DIR_W-1:0]  dir_raw_c
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;
  logic [LFSR_W-1:0] lfsr_step;

  // One Galois step and the hold/advance select
  always_comb begin
    lfsr_step = lfsr_q >> 1;
    if (lfsr_q[0]) begin
      lfsr_step = lfsr_step ^ LFSR_TAPS;
    end
    lfsr_d = advance ? lfsr_step : lfsr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Direction is taken from the value the register moves to on this advance
  assign dir_raw_c = lfsr_step[DIR_W-1:0];

endmodule

// File: rtl/vision_staircase_ctrl.sv
// Adaptive staircase controller for the LED-matrix visual-acuity test.
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   bus (vst_if.slave):
//     key_restart, key_dir  : restart pulse and one-hot answer pulses (L,R,U,D)
//     level_idx             : level under test (0 coarsest)
//     optotype_dir          : direction shown, 0=L 1=R 2=U 3=D
//     show_valid            : waiting for an answer
//     answer_ok/answer_bad  : one-cycle scoring pulses
//     test_done, result_level, result_fail : final result, held until restart
// Optional build macro VST_TIMEOUT_EN adds a TIMEOUT_CYC response window that
// scores a missing answer as wrong.
module vision_staircase_ctrl
  import vst_pkg::*;
#(
  parameter int unsigned       NUM_LEVELS  = 8,
  parameter int unsigned       START_LEVEL = 4,
  parameter int unsigned       PASS_COUNT  = 1,
  parameter int unsigned       FAIL_COUNT  = 1,
  parameter logic [LFSR_W-1:0] LFSR_SEED   = 8'hA5,
  parameter int unsigned       TIMEOUT_CYC = 5_000_000,
  parameter int unsigned       LVL_W       = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
  input logic  sys_clk,
  input logic  sys_rst,
  vst_if.slave bus
);

  localparam int unsigned CNT_MAX = (PASS_COUNT > FAIL_COUNT) ? PASS_COUNT : FAIL_COUNT;
  localparam int unsigned CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  vst_state_e       state_q, state_d;
  vst_move_e        move_q, move_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0] ok_cnt_q, ok_cnt_d;
  logic [CNT_W-1:0] bad_cnt_q, bad_cnt_d;
  logic [DIR_W-1:0] dir_q, dir_d;
  logic             show_valid_q, show_valid_d;
  logic             answer_ok_q, answer_ok_d;
  logic             answer_bad_q, answer_bad_d;
  logic             test_done_q, test_done_d;
  logic [LVL_W-1:0] result_level_q, result_level_d;
  logic             result_fail_q, result_fail_d;

  logic             lfsr_adv_c;
  logic [DIR_W-1:0] lfsr_dir_c;
  logic [CNT_W-1:0] ok_inc_c;
  logic [CNT_W-1:0] bad_inc_c;
  logic             tmo_hit_c;

  vst_lfsr u_lfsr (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .seed     (LFSR_SEED),
    .advance  (lfsr_adv_c),
    .dir_raw_c(lfsr_dir_c)
  );

`ifdef VST_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Response window: counts only while waiting, so every entry starts at 0
  always_comb begin
    tmo_d = '0;
    if (state_q == WAIT_RESP) begin
      tmo_d = tmo_q + TMO_W'(1);
    end
  end

  assign tmo_hit_c = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_hit_c = 1'b0;
`endif

  // Saturating per-level answer counters
  assign ok_inc_c  = (ok_cnt_q == CNT_W'(CNT_MAX)) ? ok_cnt_q : ok_cnt_q + CNT_W'(1);
  assign bad_inc_c = (bad_cnt_q == CNT_W'(CNT_MAX)) ? bad_cnt_q : bad_cnt_q + CNT_W'(1);

  // Next-state and registered-output logic
  always_comb begin
    state_d        = state_q;
    move_d         = move_q;
    level_d        = level_q;
    ok_cnt_d       = ok_cnt_q;
    bad_cnt_d      = bad_cnt_q;
    dir_d          = dir_q;
    answer_ok_d    = 1'b0;
    answer_bad_d   = 1'b0;
    test_done_d    = test_done_q;
    result_level_d = result_level_q;
    result_fail_d  = result_fail_q;
    lfsr_adv_c     = 1'b0;

    if (bus.key_restart) begin
      // Restart wins over any answer presented in the same cycle
      state_d        = PRESENT;
      move_d         = NONE;
      level_d        = LVL_W'(START_LEVEL);
      ok_cnt_d       = '0;
      bad_cnt_d      = '0;
      test_done_d    = 1'b0;
      result_level_d = '0;
      result_fail_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
        end

        PRESENT: begin
          lfsr_adv_c = 1'b1;
          dir_d      = (lfsr_dir_c == dir_q) ? dir_rot(lfsr_dir_c) : lfsr_dir_c;
          state_d    = WAIT_RESP;
        end

        WAIT_RESP: begin
          // Scored here so the pulse appears the cycle after the key
          if (bus.key_dir != '0) begin
            state_d      = EVAL;
            answer_ok_d  = (bus.key_dir == dir_to_key(dir_q));
            answer_bad_d = (bus.key_dir != dir_to_key(dir_q));
          end else if (tmo_hit_c) begin
            state_d      = EVAL;
            answer_bad_d = 1'b1;
          end
        end

        EVAL: begin
          state_d = PRESENT;
          if (answer_ok_q) begin
            ok_cnt_d = ok_inc_c;
            if (ok_inc_c >= CNT_W'(PASS_COUNT)) begin
              if ((move_q == DOWN) || (level_q == LVL_W'(NUM_LEVELS - 1))) begin
                state_d        = DONE;
                test_done_d    = 1'b1;
                result_level_d = level_q;
              end else begin
                level_d   = level_q + LVL_W'(1);
                move_d    = UP;
                ok_cnt_d  = '0;
                bad_cnt_d = '0;
              end
            end
          end else begin
            bad_cnt_d = bad_inc_c;
            if (bad_inc_c >= CNT_W'(FAIL_COUNT)) begin
              if (move_q == UP) begin
                // Level above was failed after climbing: last passed level is one below
                state_d        = DONE;
                test_done_d    = 1'b1;
                result_level_d = level_q - LVL_W'(1);
              end else if (level_q == '0) begin
                state_d        = DONE;
                test_done_d    = 1'b1;
                result_fail_d  = 1'b1;
                result_level_d = '0;
              end else begin
                level_d   = level_q - LVL_W'(1);
                move_d    = DOWN;
                ok_cnt_d  = '0;
                bad_cnt_d = '0;
              end
            end
          end
        end

        DONE: begin
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end

    show_valid_d = (state_d == WAIT_RESP);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q        <= IDLE;
      move_q         <= NONE;
      level_q        <= '0;
      ok_cnt_q       <= '0;
      bad_cnt_q      <= '0;
      dir_q          <= '0;
      show_valid_q   <= 1'b0;
      answer_ok_q    <= 1'b0;
      answer_bad_q   <= 1'b0;
      test_done_q    <= 1'b0;
      result_level_q <= '0;
      result_fail_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      move_q         <= move_d;
      level_q        <= level_d;
      ok_cnt_q       <= ok_cnt_d;
      bad_cnt_q      <= bad_cnt_d;
      dir_q          <= dir_d;
      show_valid_q   <= show_valid_d;
      answer_ok_q    <= answer_ok_d;
      answer_bad_q   <= answer_bad_d;
      test_done_q    <= test_done_d;
      result_level_q <= result_level_d;
      result_fail_q  <= result_fail_d;
    end
  end

  assign bus.level_idx    = level_q;
  assign bus.optotype_dir = dir_q;
  assign bus.show_valid   = show_valid_q;
  assign bus.answer_ok    = answer_ok_q;
  assign bus.answer_bad   = answer_bad_q;
  assign bus.test_done    = test_done_q;
  assign bus.result_level = result_level_q;
  assign bus.result_fail  = result_fail_q;

endmodule

// File: tb/tb_vision_staircase_ctrl.sv
// Directed bench: dut 0 has 5 levels, dut 1 has 8 levels, both start at level 4.
module tb_vision_staircase_ctrl;

  localparam int unsigned LVL_W = 3;

  logic sys_clk = 1'b0;
  logic sys_rst;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  always #5 sys_clk = ~sys_clk;

  vst_if #(.LVL_W(LVL_W)) bus_a ();
  vst_if #(.LVL_W(LVL_W)) bus_b ();

  vision_staircase_ctrl #(
    .NUM_LEVELS(5), .START_LEVEL(4), .PASS_COUNT(1), .FAIL_COUNT(1),
    .LFSR_SEED(8'hA5), .TIMEOUT_CYC(100)
  ) dut_a (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus    (bus_a)
  );

  vision_staircase_ctrl #(
    .NUM_LEVELS(8), .START_LEVEL(4), .PASS_COUNT(1), .FAIL_COUNT(1),
    .LFSR_SEED(8'hA5), .TIMEOUT_CYC(100)
  ) dut_b (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus    (bus_b)
  );

  logic             drv_restart [2];
  logic [3:0]       drv_key     [2];
  logic [LVL_W-1:0] obs_level   [2];
  logic [1:0]       obs_dir     [2];
  logic             obs_sv      [2];
  logic             obs_ok      [2];
  logic             obs_bad     [2];
  logic             obs_done    [2];
  logic [LVL_W-1:0] obs_rlev    [2];
  logic             obs_fail    [2];
  logic [12:0]      obs_vec     [2];

  assign bus_a.key_restart = drv_restart[0];
  assign bus_a.key_dir     = drv_key[0];
  assign bus_b.key_restart = drv_restart[1];
  assign bus_b.key_dir     = drv_key[1];

  assign obs_level[0] = bus_a.level_idx;
  assign obs_dir[0]   = bus_a.optotype_dir;
  assign obs_sv[0]    = bus_a.show_valid;
  assign obs_ok[0]    = bus_a.answer_ok;
  assign obs_bad[0]   = bus_a.answer_bad;
  assign obs_done[0]  = bus_a.test_done;
  assign obs_rlev[0]  = bus_a.result_level;
  assign obs_fail[0]  = bus_a.result_fail;
  assign obs_level[1] = bus_b.level_idx;
  assign obs_dir[1]   = bus_b.optotype_dir;
  assign obs_sv[1]    = bus_b.show_valid;
  assign obs_ok[1]    = bus_b.answer_ok;
  assign obs_bad[1]   = bus_b.answer_bad;
  assign obs_done[1]  = bus_b.test_done;
  assign obs_rlev[1]  = bus_b.result_level;
  assign obs_fail[1]  = bus_b.result_fail;

  assign obs_vec[0] = {obs_level[0], obs_dir[0], obs_sv[0], obs_ok[0], obs_bad[0],
                       obs_done[0], obs_rlev[0], obs_fail[0]};
  assign obs_vec[1] = {obs_level[1], obs_dir[1], obs_sv[1], obs_ok[1], obs_bad[1],
                       obs_done[1], obs_rlev[1], obs_fail[1]};

  function automatic logic [3:0] key_of(input logic [1:0] d);
    return 4'b0001 << d;
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic restart(input int s);
    drv_restart[s] = 1'b1;
    tick();
    drv_restart[s] = 1'b0;
  endtask

  task automatic wait_show(input int s, output bit seen);
    int n;
    n = 0;
    while (obs_sv[s] !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    seen = (obs_sv[s] === 1'b1);
  endtask

  // Answers the shown optotype correctly or with the next direction; returns the pulses
  task automatic answer(input int s, input bit correct, output bit seen,
                        output logic got_ok, output logic got_bad);
    logic [1:0] d;
    wait_show(s, seen);
    d = obs_dir[s];
    if (!correct) d = d + 2'd1;
    drv_key[s] = key_of(d);
    tick();
    drv_key[s] = 4'b0000;
    got_ok  = obs_ok[s];
    got_bad = obs_bad[s];
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    tick();
    for (int s = 0; s < 2; s++) begin
      vectors++;
      if (obs_vec[s] !== 13'h0)
        $display("FAIL reset_outputs dut%0d: got %0h expected 0", s, obs_vec[s]);
      if (obs_vec[s] !== 13'h0) errors++;
    end
    tick();
    sys_rst = 1'b0;
    tick();
    // IDLE must ignore answer keys
    drv_key[0] = 4'b0001;
    tick();
    drv_key[0] = 4'b0000;
    tick();
    vectors++;
    if (obs_vec[0] !== 13'h0) begin
      $display("FAIL idle_ignores_key: got %0h expected 0", obs_vec[0]);
      errors++;
    end
  endtask

  task automatic test_all_wrong();
    logic [9:0] exp_dirs;
    bit seen;
    logic ok, bad;
    exp_dirs = {2'd0, 2'd1, 2'd2, 2'd1, 2'd2};
    restart(0);
    for (int i = 0; i < 5; i++) begin
      wait_show(0, seen);
      vectors++;
      if (!seen) begin
        $display("FAIL all_wrong.show step %0d: show_valid never rose", i);
        errors++;
      end
      vectors++;
      if (obs_level[0] !== 3'(4 - i)) begin
        $display("FAIL all_wrong.level step %0d: got %0d expected %0d", i, obs_level[0], 4 - i);
        errors++;
      end
      vectors++;
      if (obs_dir[0] !== exp_dirs[2*i +: 2]) begin
        $display("FAIL all_wrong.dir step %0d: got %0d expected %0d", i, obs_dir[0], exp_dirs[2*i +: 2]);
        errors++;
      end
      answer(0, 1'b0, seen, ok, bad);
      vectors++;
      if ({ok, bad} !== 2'b01) begin
        $display("FAIL all_wrong.pulse step %0d: ok/bad got %b%b expected 01", i, ok, bad);
        errors++;
      end
    end
    tick();
    vectors++;
    if ({obs_done[0], obs_fail[0], obs_rlev[0], obs_sv[0]} !== {1'b1, 1'b1, 3'd0, 1'b0}) begin
      $display("FAIL all_wrong.result: done=%b fail=%b rlev=%0d sv=%b expected 1 1 0 0",
               obs_done[0], obs_fail[0], obs_rlev[0], obs_sv[0]);
      errors++;
    end
  endtask

  task automatic test_all_correct();
    logic [7:0] exp_dirs;
    bit seen;
    logic ok, bad;
    exp_dirs = {2'd1, 2'd2, 2'd1, 2'd2};
    restart(1);
    for (int i = 0; i < 4; i++) begin
      wait_show(1, seen);
      vectors++;
      if (!seen || obs_level[1] !== 3'(4 + i)) begin
        $display("FAIL all_correct.level step %0d: got %0d (shown=%b) expected %0d", i, obs_level[1], seen, 4 + i);
        errors++;
      end
      vectors++;
      if (obs_dir[1] !== exp_dirs[2*i +: 2]) begin
        $display("FAIL all_correct.dir step %0d: got %0d expected %0d", i, obs_dir[1], exp_dirs[2*i +: 2]);
        errors++;
      end
      answer(1, 1'b1, seen, ok, bad);
      vectors++;
      if ({ok, bad} !== 2'b10) begin
        $display("FAIL all_correct.pulse step %0d: ok/bad got %b%b expected 10", i, ok, bad);
        errors++;
      end
      if (i == 0) begin
        tick();
        vectors++;
        if (obs_sv[1] !== 1'b0) begin
          $display("FAIL latency.n+2 show_valid: got %b expected 0", obs_sv[1]);
          errors++;
        end
        tick();
        vectors++;
        if ({obs_sv[1], obs_level[1]} !== {1'b1, 3'd5}) begin
          $display("FAIL latency.n+3 sv/level: got %b/%0d expected 1/5", obs_sv[1], obs_level[1]);
          errors++;
        end
      end
    end
    tick();
    vectors++;
    if ({obs_done[1], obs_fail[1], obs_rlev[1]} !== {1'b1, 1'b0, 3'd7}) begin
      $display("FAIL all_correct.result: done=%b fail=%b rlev=%0d expected 1 0 7",
               obs_done[1], obs_fail[1], obs_rlev[1]);
      errors++;
    end
    // Keys in DONE are dropped and the result holds
    drv_key[1] = 4'b0001;
    tick();
    drv_key[1] = 4'b0000;
    tick();
    vectors++;
    if ({obs_ok[1], obs_bad[1], obs_done[1], obs_rlev[1], obs_sv[1]} !== {1'b0, 1'b0, 1'b1, 3'd7, 1'b0}) begin
      $display("FAIL done_hold: ok=%b bad=%b done=%b rlev=%0d sv=%b expected 0 0 1 7 0",
               obs_ok[1], obs_bad[1], obs_done[1], obs_rlev[1], obs_sv[1]);
      errors++;
    end
  endtask

  // pattern bit i = answer correctly at step i; levels packed 3 bits per step
  task automatic test_sequence(input int s, input string name, input logic [2:0] pattern,
                               input logic [8:0] levels, input logic [2:0] exp_res);
    bit seen;
    logic ok, bad;
    restart(s);
    for (int i = 0; i < 3; i++) begin
      wait_show(s, seen);
      vectors++;
      if (!seen || obs_level[s] !== levels[3*i +: 3]) begin
        $display("FAIL %s.level step %0d: got %0d (shown=%b) expected %0d", name, i, obs_level[s], seen, levels[3*i +: 3]);
        errors++;
      end
      answer(s, pattern[i], seen, ok, bad);
      vectors++;
      if ({ok, bad} !== {pattern[i], ~pattern[i]}) begin
        $display("FAIL %s.pulse step %0d: ok/bad got %b%b expected %b%b", name, i, ok, bad, pattern[i], ~pattern[i]);
        errors++;
      end
    end
    tick();
    vectors++;
    if ({obs_done[s], obs_fail[s], obs_rlev[s]} !== {1'b1, 1'b0, exp_res}) begin
      $display("FAIL %s.result: done=%b fail=%b rlev=%0d expected 1 0 %0d",
               name, obs_done[s], obs_fail[s], obs_rlev[s], exp_res);
      errors++;
    end
  endtask

  task automatic test_edge_keys();
    bit seen;
    restart(0);
    wait_show(0, seen);
    drv_key[0] = 4'b0011;
    tick();
    drv_key[0] = 4'b0000;
    vectors++;
    if ({obs_ok[0], obs_bad[0]} !== 2'b01) begin
      $display("FAIL multi_key: ok/bad got %b%b expected 01", obs_ok[0], obs_bad[0]);
      errors++;
    end
    wait_show(0, seen);
    vectors++;
    if (obs_level[0] !== 3'd3) begin
      $display("FAIL multi_key.level: got %0d expected 3", obs_level[0]);
      errors++;
    end
    // Restart together with a correct key: restart wins
    drv_restart[0] = 1'b1;
    drv_key[0]     = key_of(obs_dir[0]);
    tick();
    drv_restart[0] = 1'b0;
    // Now in PRESENT: this key must be dropped
    drv_key[0] = 4'b0001;
    vectors++;
    if ({obs_ok[0], obs_bad[0], obs_sv[0], obs_level[0]} !== {1'b0, 1'b0, 1'b0, 3'd4}) begin
      $display("FAIL restart_wins: ok=%b bad=%b sv=%b level=%0d expected 0 0 0 4",
               obs_ok[0], obs_bad[0], obs_sv[0], obs_level[0]);
      errors++;
    end
    tick();
    drv_key[0] = 4'b0000;
    tick();
    vectors++;
    if ({obs_ok[0], obs_bad[0], obs_sv[0], obs_level[0]} !== {1'b0, 1'b0, 1'b1, 3'd4}) begin
      $display("FAIL key_outside_wait: ok=%b bad=%b sv=%b level=%0d expected 0 0 1 4",
               obs_ok[0], obs_bad[0], obs_sv[0], obs_level[0]);
      errors++;
    end
  endtask

`ifdef VST_TIMEOUT_EN
  task automatic test_timeout();
    bit seen;
    int n;
    restart(0);
    wait_show(0, seen);
    n = 0;
    while (obs_sv[0] === 1'b1 && n < 300) begin
      tick();
      n++;
    end
    vectors++;
    if (n != 100 || obs_bad[0] !== 1'b1 || obs_ok[0] !== 1'b0) begin
      $display("FAIL timeout: waited %0d cycles bad=%b ok=%b expected 100 1 0", n, obs_bad[0], obs_ok[0]);
      errors++;
    end
    tick();
    vectors++;
    if (obs_level[0] !== 3'd3) begin
      $display("FAIL timeout.level: got %0d expected 3", obs_level[0]);
      errors++;
    end
  endtask
`endif

  task automatic test_reset_mid();
    bit seen;
    logic ok, bad;
    restart(1);
    answer(1, 1'b1, seen, ok, bad);
    wait_show(1, seen);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      vectors++;
      if (obs_vec[s] !== 13'h0) begin
        $display("FAIL reset_mid dut%0d: got %0h expected 0", s, obs_vec[s]);
        errors++;
      end
    end
    // LFSR and previous direction reloaded: first direction repeats
    restart(1);
    wait_show(1, seen);
    vectors++;
    if (!seen || obs_dir[1] !== 2'd2 || obs_level[1] !== 3'd4) begin
      $display("FAIL reset_mid.reseed: dir=%0d level=%0d shown=%b expected 2 4 1", obs_dir[1], obs_level[1], seen);
      errors++;
    end
  endtask

  initial begin
    sys_rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      drv_restart[s] = 1'b0;
      drv_key[s]     = 4'b0000;
    end
    test_reset();
    test_all_wrong();
    test_all_correct();
    test_sequence(0, "wrong_wrong_right", 3'b100, {3'd2, 3'd3, 3'd4}, 3'd2);
    test_sequence(1, "right_right_wrong", 3'b011, {3'd6, 3'd5, 3'd4}, 3'd5);
    test_edge_keys();
`ifdef VST_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
